// File: rtl/tipi_nib_pkg.sv
// Shared types and constants for the TIPI Pi-side nibble port.
package tipi_nib_pkg;

  // Frame progress: command nibble, high nibble, low nibble, then finished or faulted.
  typedef enum logic [2:0] {
    ST_CMD  = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } nib_state_t;

  // Command nibbles as numeric values (TI bit 0 is the MSB, i.e. our bit 3).
  localparam logic [3:0] CMD_RD_TD = 4'h8;
  localparam logic [3:0] CMD_RD_TC = 4'h9;
  localparam logic [3:0] CMD_WR_RD = 4'h0;
  localparam logic [3:0] CMD_WR_RC = 4'h1;

  localparam int DEFAULT_SYNC_STAGES = 2;

  // True for the four command nibbles the port understands.
  function automatic logic cmd_valid(input logic [3:0] cmd);
    return (cmd == CMD_RD_TD) || (cmd == CMD_RD_TC) ||
           (cmd == CMD_WR_RD) || (cmd == CMD_WR_RC);
  endfunction

  // True for the two read commands.
  function automatic logic cmd_is_read(input logic [3:0] cmd);
    return (cmd == CMD_RD_TD) || (cmd == CMD_RD_TC);
  endfunction

endpackage

// File: rtl/tipi_sync_edge.sv
// N-stage synchroniser for an asynchronous Pi input, with a registered
// single-cycle rising-edge pulse. level is the synchronised input; rise is
// high for one cycle, STAGES+1 clocks after the pin rises.
module tipi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;
  logic              rise_reg;

  // Shift the pin through the synchroniser chain, then detect a 0->1 step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
      prev_reg <= sync_reg[STAGES-1];
      rise_reg <= sync_reg[STAGES-1] & ~prev_reg;
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = rise_reg;

endmodule

// File: rtl/tipi_nib_port.sv
// Pi-side nibble transfer engine: three r_clk edges per frame (command,
// high nibble, low nibble). Reads stream a snapshot of TD/TC to the Pi,
// writes assemble a byte for RD/RC and pulse the matching write strobe.
// Byte buses are numeric: TI bit 0 (MSB) is bit 7 here, so TI [0:3] is [7:4].
module tipi_nib_port
  import tipi_nib_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       r_clk,
  input  logic       r_nibrst,
  input  logic [3:0] r_nib_i,
  output logic [3:0] r_nib_o,
  output logic       r_nib_oe,
  input  logic [7:0] td_q,
  input  logic [7:0] tc_q,
  output logic [7:0] rd_d,
  output logic       rd_we,
  output logic [7:0] rc_d,
  output logic       rc_we,
  output logic       busy,
  output logic       frame_err
);

  logic clk_lvl, clk_rise;
  logic nibrst_lvl, nibrst_rise;

  tipi_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .d     (r_clk),
    .level (clk_lvl),
    .rise  (clk_rise)
  );

  tipi_sync_edge #(.STAGES(SYNC_STAGES)) u_nibrst_sync (
    .clk   (clk),
    .reset (reset),
    .d     (r_nibrst),
    .level (nibrst_lvl),
    .rise  (nibrst_rise)
  );

  // Only the strobe edge and the frame-reset level are needed.
  logic unused_sync;
  assign unused_sync = &{1'b0, clk_lvl, nibrst_rise};

  nib_state_t state_reg, state_next;
  logic       is_read_reg, is_read_next;
  logic       sel_c_reg, sel_c_next;
  logic [7:0] snap_reg, snap_next;
  logic [3:0] hi_reg, hi_next;
  logic [7:0] rd_d_reg, rd_d_next;
  logic [7:0] rc_d_reg, rc_d_next;
  logic       rd_we_reg, rd_we_next;
  logic       rc_we_reg, rc_we_next;
  logic       err_reg, err_next;
  logic [3:0] nib_o_reg, nib_o_next;
  logic       nib_oe_reg, nib_oe_next;

  // State and datapath registers; async reset returns every output to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_CMD;
      is_read_reg <= 1'b0;
      sel_c_reg   <= 1'b0;
      snap_reg    <= 8'h00;
      hi_reg      <= 4'h0;
      rd_d_reg    <= 8'h00;
      rc_d_reg    <= 8'h00;
      rd_we_reg   <= 1'b0;
      rc_we_reg   <= 1'b0;
      err_reg     <= 1'b0;
      nib_o_reg   <= 4'h0;
      nib_oe_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      is_read_reg <= is_read_next;
      sel_c_reg   <= sel_c_next;
      snap_reg    <= snap_next;
      hi_reg      <= hi_next;
      rd_d_reg    <= rd_d_next;
      rc_d_reg    <= rc_d_next;
      rd_we_reg   <= rd_we_next;
      rc_we_reg   <= rc_we_next;
      err_reg     <= err_next;
      nib_o_reg   <= nib_o_next;
      nib_oe_reg  <= nib_oe_next;
    end
  end

  // Next-state and output decode; frame reset overrides any recognised edge.
  always_comb begin
    state_next   = state_reg;
    is_read_next = is_read_reg;
    sel_c_next   = sel_c_reg;
    snap_next    = snap_reg;
    hi_next      = hi_reg;
    rd_d_next    = rd_d_reg;
    rc_d_next    = rc_d_reg;
    rd_we_next   = 1'b0;
    rc_we_next   = 1'b0;
    err_next     = err_reg;
    nib_o_next   = 4'h0;
    nib_oe_next  = 1'b0;

    if (nibrst_lvl) begin
      state_next = ST_CMD;
      err_next   = 1'b0;
    end else if (clk_rise) begin
      case (state_reg)
        ST_CMD: begin
          if (cmd_valid(r_nib_i)) begin
            is_read_next = cmd_is_read(r_nib_i);
            sel_c_next   = (r_nib_i == CMD_RD_TC) || (r_nib_i == CMD_WR_RC);
            if (cmd_is_read(r_nib_i)) begin
              snap_next = (r_nib_i == CMD_RD_TC) ? tc_q : td_q;
            end
            state_next = ST_HI;
          end else begin
            err_next   = 1'b1;
            state_next = ST_ERR;
          end
        end
        ST_HI: begin
          if (!is_read_reg) begin
            hi_next = r_nib_i;
          end
          state_next = ST_LO;
        end
        ST_LO: begin
          if (!is_read_reg) begin
            if (sel_c_reg) begin
              rc_d_next  = {hi_reg, r_nib_i};
              rc_we_next = 1'b1;
            end else begin
              rd_d_next  = {hi_reg, r_nib_i};
              rd_we_next = 1'b1;
            end
          end
          state_next = ST_DONE;
        end
        ST_DONE: begin
          err_next   = 1'b1;
          state_next = ST_ERR;
        end
        default: state_next = state_reg;
      endcase
    end

    // Drive the Pi only while a read frame sits in HI or LO.
    if (is_read_next && (state_next == ST_HI)) begin
      nib_oe_next = 1'b1;
      nib_o_next  = snap_next[7:4];
    end else if (is_read_next && (state_next == ST_LO)) begin
      nib_oe_next = 1'b1;
      nib_o_next  = snap_next[3:0];
    end
  end

  assign r_nib_o   = nib_o_reg;
  assign r_nib_oe  = nib_oe_reg;
  assign rd_d      = rd_d_reg;
  assign rd_we     = rd_we_reg;
  assign rc_d      = rc_d_reg;
  assign rc_we     = rc_we_reg;
  assign frame_err = err_reg;
  assign busy      = (state_reg == ST_HI) || (state_reg == ST_LO);

endmodule

// File: tb/tb_tipi_nib_port.sv
// Directed bench for tipi_nib_port: Pi-side frames driven with slow r_clk
// strobes, outputs sampled on the falling clock edge.
module tb_tipi_nib_port;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       r_clk = 1'b0;
  logic       r_nibrst = 1'b0;
  logic [3:0] r_nib_i = 4'h0;
  logic [3:0] r_nib_o;
  logic       r_nib_oe;
  logic [7:0] td_q = 8'h00;
  logic [7:0] tc_q = 8'h00;
  logic [7:0] rd_d;
  logic       rd_we;
  logic [7:0] rc_d;
  logic       rc_we;
  logic       busy;
  logic       frame_err;

  int vectors = 0;
  int miscompares = 0;

  // Strobe monitors: pulses counted on rising edges, width in high cycles.
  int  rd_pulses = 0, rd_cycles = 0, rc_pulses = 0, rc_cycles = 0;
  logic rd_we_d = 1'b0, rc_we_d = 1'b0;
  int  rd_p0, rd_c0, rc_p0, rc_c0;

  tipi_nib_port #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .r_clk     (r_clk),
    .r_nibrst  (r_nibrst),
    .r_nib_i   (r_nib_i),
    .r_nib_o   (r_nib_o),
    .r_nib_oe  (r_nib_oe),
    .td_q      (td_q),
    .tc_q      (tc_q),
    .rd_d      (rd_d),
    .rd_we     (rd_we),
    .rc_d      (rc_d),
    .rc_we     (rc_we),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_we_d <= rd_we;
    rc_we_d <= rc_we;
    if (rd_we) rd_cycles <= rd_cycles + 1;
    if (rc_we) rc_cycles <= rc_cycles + 1;
    if (rd_we && !rd_we_d) rd_pulses <= rd_pulses + 1;
    if (rc_we && !rc_we_d) rc_pulses <= rc_pulses + 1;
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One Pi strobe: present the nibble, raise r_clk, hold, drop, settle.
  task automatic pi_edge(input logic [3:0] nib);
    r_nib_i = nib;
    @(posedge clk); #1 r_clk = 1'b1;
    repeat (5) @(posedge clk);
    #1 r_clk = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pi_nibrst();
    @(posedge clk); #1 r_nibrst = 1'b1;
    repeat (6) @(posedge clk);
    #1 r_nibrst = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic snap_strobes();
    rd_p0 = rd_pulses; rd_c0 = rd_cycles;
    rc_p0 = rc_pulses; rc_c0 = rc_cycles;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    expect_eq("rst_nib_o", r_nib_o, 4'h0);
    expect_eq("rst_oe", r_nib_oe, 1'b0);
    expect_eq("rst_rd_d", rd_d, 8'h00);
    expect_eq("rst_rc_d", rc_d, 8'h00);
    expect_eq("rst_busy", busy, 1'b0);
    expect_eq("rst_err", frame_err, 1'b0);

    // Read TD = AA
    td_q = 8'hAA;
    pi_edge(4'h8);
    expect_eq("rdtd_busy", busy, 1'b1);
    expect_eq("rdtd_oe1", r_nib_oe, 1'b1);
    expect_eq("rdtd_hi", r_nib_o, 4'hA);
    pi_edge(4'h0);
    expect_eq("rdtd_oe2", r_nib_oe, 1'b1);
    expect_eq("rdtd_lo", r_nib_o, 4'hA);
    pi_edge(4'h0);
    expect_eq("rdtd_oe3", r_nib_oe, 1'b0);
    expect_eq("rdtd_busy3", busy, 1'b0);
    expect_eq("rdtd_err", frame_err, 1'b0);

    // Read TD = 3C: nibble order
    pi_nibrst();
    td_q = 8'h3C;
    pi_edge(4'h8);
    expect_eq("rd3c_hi", r_nib_o, 4'h3);
    pi_edge(4'h0);
    expect_eq("rd3c_lo", r_nib_o, 4'hC);
    pi_edge(4'h0);

    // Write RC 5C
    pi_nibrst();
    snap_strobes();
    pi_edge(4'h1);
    pi_edge(4'h5);
    expect_eq("wrrc_oe", r_nib_oe, 1'b0);
    pi_edge(4'hC);
    expect_eq("wrrc_pulses", rc_pulses - rc_p0, 1);
    expect_eq("wrrc_width", rc_cycles - rc_c0, 1);
    expect_eq("wrrc_data", rc_d, 8'h5C);
    expect_eq("wrrc_no_rd", rd_pulses - rd_p0, 0);
    expect_eq("wrrc_busy", busy, 1'b0);
    expect_eq("wrrc_rd_d", rd_d, 8'h00);

    // Snapshot: TC changes after the command edge
    pi_nibrst();
    tc_q = 8'h55;
    pi_edge(4'h9);
    tc_q = 8'hFF;
    expect_eq("snap_hi", r_nib_o, 4'h5);
    pi_edge(4'h0);
    expect_eq("snap_lo", r_nib_o, 4'h5);
    pi_edge(4'h0);

    // Abort mid-write, then a clean write RD
    pi_nibrst();
    snap_strobes();
    pi_edge(4'h0);
    pi_edge(4'h3);
    pi_nibrst();
    expect_eq("abort_busy", busy, 1'b0);
    expect_eq("abort_no_we", rd_pulses - rd_p0, 0);
    pi_edge(4'h0);
    pi_edge(4'h7);
    pi_edge(4'hE);
    expect_eq("abort_pulses", rd_pulses - rd_p0, 1);
    expect_eq("abort_width", rd_cycles - rd_c0, 1);
    expect_eq("abort_rd_d", rd_d, 8'h7E);
    expect_eq("abort_rc_held", rc_d, 8'h5C);

    // Bad command nibble
    pi_nibrst();
    pi_edge(4'h4);
    expect_eq("badcmd_err", frame_err, 1'b1);
    expect_eq("badcmd_oe", r_nib_oe, 1'b0);
    expect_eq("badcmd_busy", busy, 1'b0);
    pi_edge(4'h8);
    expect_eq("err_ignores", r_nib_oe, 1'b0);
    pi_nibrst();
    expect_eq("badcmd_clr", frame_err, 1'b0);

    // Fourth edge after a complete frame
    pi_edge(4'h8);
    pi_edge(4'h0);
    pi_edge(4'h0);
    expect_eq("frame4_pre", frame_err, 1'b0);
    pi_edge(4'h0);
    expect_eq("frame4_err", frame_err, 1'b1);
    pi_nibrst();
    expect_eq("frame4_clr", frame_err, 1'b0);

    // Async reset while a write sits in LO
    snap_strobes();
    pi_edge(4'h0);
    pi_edge(4'h9);
    expect_eq("arst_in_lo", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    expect_eq("arst_busy", busy, 1'b0);
    expect_eq("arst_rd_d", rd_d, 8'h00);
    expect_eq("arst_rc_d", rc_d, 8'h00);
    expect_eq("arst_oe", r_nib_oe, 1'b0);
    expect_eq("arst_nib_o", r_nib_o, 4'h0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    expect_eq("arst_no_we", rd_pulses - rd_p0, 0);
    expect_eq("arst_we_low", rd_we, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
